// File: rtl/serial_link_pkg.sv
// Shared definitions for the parity serial link (transmitter and receiver).
// - tx_state_e : frame state machine encoding
// - line levels: START_BIT, STOP_BIT, LINE_IDLE
// - parity modes: EVEN, ODD
// - line_level(): serial level driven for a given state
package serial_link_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_e;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;
  localparam logic LINE_IDLE = 1'b1;

  localparam int EVEN = 0;
  localparam int ODD  = 1;

  // Level on the line while in state s.
  // data_bit is the current LSB of the shift register.
  // par is the latched parity bit.
  function automatic logic line_level(tx_state_e s, logic data_bit, logic par);
    case (s)
      START:   return START_BIT;
      DATA:    return data_bit;
      PARITY:  return par;
      STOP:    return STOP_BIT;
      default: return LINE_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/bit_timer.sv
// Bit-period timer: counts CLKS_PER_BIT cycles per serial bit.
// Ports:
//   clk   - system clock
//   reset - synchronous active-high reset
//   clr   - hold the counter at zero (line idle)
//   tick  - high on the last cycle of each bit period
module bit_timer #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  // With one clock per bit LAST is 0, so the tick is permanent and cnt stays 0.
  assign tick = (cnt == LAST);

  always_ff @(posedge clk) begin
    if (reset || clr || tick) cnt <= '0;
    else                      cnt <= cnt + CW'(1);
  end

endmodule

// File: rtl/serial_parity_tx.sv
// Parity-framed serial transmitter.
// Frame format: start(0), DATA_W data bits LSB-first, parity, stop(1).
// Ports:
//   clk, reset - clock, synchronous active-high reset
//   tx_data    - word to send, latched on the valid/ready handshake
//   tx_valid   - producer has a word
//   tx_ready   - idle, able to accept a word
//   tx_serial  - registered serial line, idles high
//   busy       - frame in progress
//   done       - pulse on the last cycle of the stop bit
module serial_parity_tx
  import serial_link_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY_ODD   = EVEN
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              tx_serial,
  output logic              busy,
  output logic              done
);

  localparam int BW = $clog2(DATA_W + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

  tx_state_e         state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic              par_q, par_d;
  logic              tick;

  bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .clk   (clk),
    .reset (reset),
    .clr   (state_q == IDLE),
    .tick  (tick)
  );

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    bit_d   = bit_q;
    par_d   = par_q;
    case (state_q)
      IDLE: if (tx_valid && tx_ready) begin
        shreg_d = tx_data;
        // Reduction XOR gives even parity; XOR with the mode flips it to odd (XNOR).
        par_d   = (^tx_data) ^ 1'(PARITY_ODD);
        state_d = START;
      end
      START:  if (tick) state_d = DATA;
      DATA: if (tick) begin
        shreg_d = shreg_q >> 1;
        if (bit_q == LAST_BIT) begin
          bit_d   = '0;
          state_d = PARITY;
        end else begin
          bit_d = bit_q + BW'(1);
        end
      end
      PARITY: if (tick) state_d = STOP;
      STOP:   if (tick) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Line and handshake outputs are registered from next-state values,
  // so they change on the same edge as the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      bit_q     <= '0;
      par_q     <= 1'b0;
      tx_serial <= LINE_IDLE;
      tx_ready  <= 1'b1;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_q     <= bit_d;
      par_q     <= par_d;
      tx_serial <= line_level(state_d, shreg_d[0], par_d);
      tx_ready  <= (state_d == IDLE);
      busy      <= (state_d != IDLE);
    end
  end

  // Decoded from registered state and timer count only.
  assign done = (state_q == STOP) && tick;

endmodule

// File: tb/tb_serial_parity_tx.sv
module tb_serial_parity_tx;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // A: defaults (8 bits, 4 clk/bit, even)
  logic [7:0] a_data;
  logic a_valid, a_ready, a_serial, a_busy, a_done;
  // B: odd parity
  logic [7:0] b_data;
  logic b_valid, b_ready, b_serial, b_busy, b_done;
  // C: 4 bits, 1 clk/bit, even
  logic [3:0] c_data;
  logic c_valid, c_ready, c_serial, c_busy, c_done;

  serial_parity_tx u_a (
    .clk(clk), .reset(reset), .tx_data(a_data), .tx_valid(a_valid),
    .tx_ready(a_ready), .tx_serial(a_serial), .busy(a_busy), .done(a_done));

  serial_parity_tx #(.PARITY_ODD(1)) u_b (
    .clk(clk), .reset(reset), .tx_data(b_data), .tx_valid(b_valid),
    .tx_ready(b_ready), .tx_serial(b_serial), .busy(b_busy), .done(b_done));

  serial_parity_tx #(.DATA_W(4), .CLKS_PER_BIT(1)) u_c (
    .clk(clk), .reset(reset), .tx_data(c_data), .tx_valid(c_valid),
    .tx_ready(c_ready), .tx_serial(c_serial), .busy(c_busy), .done(c_done));

  int passed = 0;
  int failed = 0;
  int total  = 0;
  int dsel   = 0;

  logic s_serial, s_ready, s_busy, s_done;
  always_comb begin
    s_serial = a_serial; s_ready = a_ready; s_busy = a_busy; s_done = a_done;
    if (dsel == 1) begin
      s_serial = b_serial; s_ready = b_ready; s_busy = b_busy; s_done = b_done;
    end else if (dsel == 2) begin
      s_serial = c_serial; s_ready = c_ready; s_busy = c_busy; s_done = c_done;
    end
  end

  task automatic chk(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      failed++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Called in cycle 1 of a frame (just after the handshake edge).
  // f holds the expected line bits, first bit in f[10].
  task automatic frame_check(input string tag, input int nb, input int cpb,
                             input logic [10:0] f, input bit poke);
    for (int b = 0; b < nb; b++) begin
      for (int c = 0; c < cpb; c++) begin
        int cyc;
        cyc = b * cpb + c + 1;
        chk($sformatf("%s serial b%0d c%0d", tag, b, c), s_serial, f[10-b]);
        chk($sformatf("%s busy cyc%0d", tag, cyc), s_busy, 1'b1);
        chk($sformatf("%s ready cyc%0d", tag, cyc), s_ready, 1'b0);
        chk($sformatf("%s done cyc%0d", tag, cyc), s_done,
            (b == nb - 1) && (c == cpb - 1));
        if (poke && cyc == 10) begin a_data = 8'hFF; a_valid = 1'b1; end
        if (poke && cyc == 30) a_valid = 1'b0;
        step();
      end
    end
    chk({tag, " end ready"},  s_ready,  1'b1);
    chk({tag, " end busy"},   s_busy,   1'b0);
    chk({tag, " end serial"}, s_serial, 1'b1);
    chk({tag, " end done"},   s_done,   1'b0);
  endtask

  initial begin
    reset = 1'b1;
    a_data = 8'h55; a_valid = 1'b1;  // offered during reset: must be ignored
    b_data = 8'h00; b_valid = 1'b0;
    c_data = 4'h0;  c_valid = 1'b0;
    step(); step();
    chk("rst a serial", a_serial, 1'b1);
    chk("rst a ready",  a_ready,  1'b1);
    chk("rst a busy",   a_busy,   1'b0);
    chk("rst a done",   a_done,   1'b0);
    chk("rst b serial", b_serial, 1'b1);
    chk("rst c ready",  c_ready,  1'b1);
    a_valid = 1'b0; reset = 1'b0;
    step();
    chk("post rst a busy", a_busy, 1'b0);

    // A5, even parity 0
    dsel = 0; a_data = 8'hA5; a_valid = 1'b1;
    step(); a_valid = 1'b0;
    frame_check("a5", 11, 4, 11'b01010010101, 1'b0);

    // 07, even parity 1
    a_data = 8'h07; a_valid = 1'b1;
    step(); a_valid = 1'b0;
    frame_check("07", 11, 4, 11'b01110000011, 1'b0);

    // Back-to-back 3C then C3 with valid held high
    a_data = 8'h3C; a_valid = 1'b1;
    step(); a_data = 8'hC3;
    frame_check("3c", 11, 4, 11'b00011110001, 1'b0);
    step(); a_valid = 1'b0;  // C3 accepted on the single idle cycle
    frame_check("c3", 11, 4, 11'b01100001101, 1'b0);

    // 12 with tx_data/tx_valid disturbed mid-frame
    a_data = 8'h12; a_valid = 1'b1;
    step(); a_valid = 1'b0;
    frame_check("12", 11, 4, 11'b00100100001, 1'b1);
    step();
    chk("12 no extra handshake", a_busy, 1'b0);

    // Reset during data bit 3 of A5 (cycles 17..20)
    a_data = 8'hA5; a_valid = 1'b1;
    step(); a_valid = 1'b0;
    repeat (16) step();
    chk("mid bit3 serial", a_serial, 1'b0);
    chk("mid bit3 busy",   a_busy,   1'b1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("midrst serial", a_serial, 1'b1);
    chk("midrst ready",  a_ready,  1'b1);
    chk("midrst busy",   a_busy,   1'b0);
    chk("midrst done",   a_done,   1'b0);
    for (int i = 0; i < 30; i++) begin
      step();
      chk($sformatf("midrst quiet done %0d", i), a_done, 1'b0);
      chk($sformatf("midrst quiet line %0d", i), a_serial, 1'b1);
    end
    a_data = 8'h81; a_valid = 1'b1;
    step(); a_valid = 1'b0;
    frame_check("81", 11, 4, 11'b01000000101, 1'b0);

    // Odd parity instance
    dsel = 1; b_data = 8'h00; b_valid = 1'b1;
    step(); b_valid = 1'b0;
    frame_check("odd00", 11, 4, 11'b00000000011, 1'b0);
    b_data = 8'hFF; b_valid = 1'b1;
    step(); b_valid = 1'b0;
    frame_check("oddff", 11, 4, 11'b01111111111, 1'b0);

    // 4-bit, 1 clk/bit instance: B -> 0,1,1,0,1,1,1
    dsel = 2; c_data = 4'hB; c_valid = 1'b1;
    step(); c_valid = 1'b0;
    frame_check("c_b", 7, 1, 11'b01101110000, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
